gpio_bank: RTL and testbench

GPIO_BANK -- requirements
Module: gpio_bank

---
 rtl/gpio_bank_pkg.sv | 18 +
 rtl/gpio_bank_chan.sv | 73 +++++++
 rtl/gpio_bank.sv | 103 ++++++++++
 tb/tb_gpio_bank.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_bank_pkg.sv
// Shared constants for the GPIO bank: register addresses and pad-enable reset value.
package gpio_bank_pkg;

  typedef enum logic [2:0] {
    ADDR_DATA_OUT   = 3'd0,
    ADDR_OEB        = 3'd1,
    ADDR_DATA_IN    = 3'd2,
    ADDR_IRQ_EN     = 3'd3,
    ADDR_IRQ_EDGE   = 3'd4,
    ADDR_IRQ_STATUS = 3'd5,
    ADDR_DATA_SET   = 3'd6,
    ADDR_DATA_CLR   = 3'd7
  } gpio_addr_e;

  // Pins come out of reset as inputs (output driver disabled).
  localparam logic OEB_RST_BIT = 1'b1;

endpackage

// File: rtl/gpio_bank_chan.sv
// One GPIO input channel: pad synchronizer, optional debounce filter, edge detect.
// Define GPIO_BANK_DEBOUNCE_EN to build in the debounce filter.
module gpio_bank_chan #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic core_clk,
  input  logic core_rstn,
  input  logic pad_i,
  output logic data_in_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;
  logic                   filt;
  logic                   prev_q;

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("gpio_bank_chan: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) sync_q <= '0;
    else            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
  end

  assign sync_bit = sync_q[SYNC_STAGES-1];

`ifdef GPIO_BANK_DEBOUNCE_EN
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // The commit edge is the DEBOUNCE_CYCLES-th consecutive mismatching cycle;
  // the >= compare keeps the counter saturated below the window.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_bit != filt_q) begin
      if (cnt_q >= CNT_LAST) filt_d = sync_bit;
      else                   cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync_bit;
`endif

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) prev_q <= 1'b0;
    else            prev_q <= filt;
  end

  assign data_in_o = filt;
  assign rise_o    = filt & ~prev_q;
  assign fall_o    = ~filt & prev_q;

endmodule

// File: rtl/gpio_bank.sv
// GPIO bank: register file, per-pin input channels and W1C edge interrupts.
// Define GPIO_BANK_DEBOUNCE_EN to build the per-pin debounce filter into each channel.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             core_clk,
  input  logic             core_rstn,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] pad_o,
  output logic [WIDTH-1:0] pad_oeb,
  input  logic             reg_we,
  input  logic [2:0]       reg_addr,
  input  logic [WIDTH-1:0] reg_wdata,
  output logic [WIDTH-1:0] reg_rdata,
  output logic             irq
);

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] oeb_q, oeb_d;
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [WIDTH-1:0] irq_edge_q, irq_edge_d;
  logic [WIDTH-1:0] irq_status_q, irq_status_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] data_in, rise, fall, irq_event, w1c;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    gpio_bank_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .core_clk (core_clk),
      .core_rstn(core_rstn),
      .pad_i    (pad_i[gi]),
      .data_in_o(data_in[gi]),
      .rise_o   (rise[gi]),
      .fall_o   (fall[gi])
    );
  end

  assign irq_event = irq_en_q & ((irq_edge_q & rise) | (~irq_edge_q & fall));

  always_comb begin
    data_out_d = data_out_q;
    oeb_d      = oeb_q;
    irq_en_d   = irq_en_q;
    irq_edge_d = irq_edge_q;
    w1c        = '0;
    if (reg_we) begin
      case (reg_addr)
        ADDR_DATA_OUT:   data_out_d = reg_wdata;
        ADDR_OEB:        oeb_d      = reg_wdata;
        ADDR_IRQ_EN:     irq_en_d   = reg_wdata;
        ADDR_IRQ_EDGE:   irq_edge_d = reg_wdata;
        ADDR_IRQ_STATUS: w1c        = reg_wdata;
        ADDR_DATA_SET:   data_out_d = data_out_q | reg_wdata;
        ADDR_DATA_CLR:   data_out_d = data_out_q & ~reg_wdata;
        default: ;
      endcase
    end
    // A new edge outranks a clear landing on the same bit in the same cycle.
    irq_status_d = (irq_status_q & ~w1c) | irq_event;
  end

  always_comb begin
    case (reg_addr)
      ADDR_DATA_OUT:   rdata_d = data_out_q;
      ADDR_OEB:        rdata_d = oeb_q;
      ADDR_DATA_IN:    rdata_d = data_in;
      ADDR_IRQ_EN:     rdata_d = irq_en_q;
      ADDR_IRQ_EDGE:   rdata_d = irq_edge_q;
      ADDR_IRQ_STATUS: rdata_d = irq_status_q;
      default:         rdata_d = '0;
    endcase
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      data_out_q   <= '0;
      oeb_q        <= {WIDTH{OEB_RST_BIT}};
      irq_en_q     <= '0;
      irq_edge_q   <= '0;
      irq_status_q <= '0;
      rdata_q      <= '0;
    end else begin
      data_out_q   <= data_out_d;
      oeb_q        <= oeb_d;
      irq_en_q     <= irq_en_d;
      irq_edge_q   <= irq_edge_d;
      irq_status_q <= irq_status_d;
      rdata_q      <= rdata_d;
    end
  end

  assign pad_o     = data_out_q;
  assign pad_oeb   = oeb_q;
  assign reg_rdata = rdata_q;
  assign irq       = |irq_status_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank against a cycle-level behavioural model.
// Covers both builds; the debounce scenarios follow GPIO_BANK_DEBOUNCE_EN.
`timescale 1ns/1ps
module tb_gpio_bank;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int DC = 16;
`ifdef GPIO_BANK_DEBOUNCE_EN
  localparam int LAT          = S + DC;
  localparam int TOGGLE_ODDS  = 40;
`else
  localparam int LAT          = S;
  localparam int TOGGLE_ODDS  = 4;
`endif
  localparam logic [W-1:0] ONES = '1;

  logic         core_clk  = 1'b0;
  logic         core_rstn = 1'b0;
  logic [W-1:0] pad_i     = '0;
  logic         reg_we    = 1'b0;
  logic [2:0]   reg_addr  = '0;
  logic [W-1:0] reg_wdata = '0;
  logic [W-1:0] pad_o, pad_oeb, reg_rdata;
  logic         irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 core_clk = ~core_clk;

  gpio_bank #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DC)) dut (
    .core_clk (core_clk),
    .core_rstn(core_rstn),
    .pad_i    (pad_i),
    .pad_o    (pad_o),
    .pad_oeb  (pad_oeb),
    .reg_we   (reg_we),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata),
    .irq      (irq)
  );

  // Reference model state
  logic [W-1:0] m_out, m_oeb, m_en, m_edge, m_stat, m_rdata;
  logic [W-1:0] m_din, m_din_prev, m_sync;
  logic [W-1:0] pad_q[$];
  int           run[W];

  task automatic model_reset();
    m_out = '0; m_oeb = ONES; m_en = '0; m_edge = '0; m_stat = '0; m_rdata = '0;
    m_din = '0; m_din_prev = '0; m_sync = '0;
    pad_q.delete();
    for (int i = 0; i < W; i++) run[i] = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [W-1:0] ev, w1c, rd, st;
    ev = m_en & ((m_edge & m_din & ~m_din_prev) | (~m_edge & ~m_din & m_din_prev));
    case (reg_addr)
      3'd0:    rd = m_out;
      3'd1:    rd = m_oeb;
      3'd2:    rd = m_din;
      3'd3:    rd = m_en;
      3'd4:    rd = m_edge;
      3'd5:    rd = m_stat;
      default: rd = '0;
    endcase
    w1c = (reg_we && reg_addr == 3'd5) ? reg_wdata : '0;
    st  = (m_stat & ~w1c) | ev;
    if (reg_we) begin
      case (reg_addr)
        3'd0: m_out  = reg_wdata;
        3'd1: m_oeb  = reg_wdata;
        3'd3: m_en   = reg_wdata;
        3'd4: m_edge = reg_wdata;
        3'd6: m_out  = m_out | reg_wdata;
        3'd7: m_out  = m_out & ~reg_wdata;
        default: ;
      endcase
    end
    m_stat     = st;
    m_rdata    = rd;
    m_din_prev = m_din;
`ifdef GPIO_BANK_DEBOUNCE_EN
    for (int i = 0; i < W; i++) begin
      if (m_sync[i] !== m_din[i]) begin
        run[i]++;
        if (run[i] >= DC) begin
          m_din[i] = m_sync[i];
          run[i]   = 0;
        end
      end else begin
        run[i] = 0;
      end
    end
`endif
    pad_q.push_back(pad_i);
    if (pad_q.size() > S) void'(pad_q.pop_front());
    m_sync = (pad_q.size() == S) ? pad_q[0] : '0;
`ifndef GPIO_BANK_DEBOUNCE_EN
    m_din = m_sync;
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge core_clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_we = 1'b0;
  endtask

  task automatic apply_reset();
    core_rstn = 1'b0; reg_we = 1'b0;
    model_reset();
    repeat (2) @(posedge core_clk);
    #1;
    core_rstn = 1'b1;
  endtask

  task automatic test_reset();
    logic [W-1:0] exp;
    pad_i = '0;
    apply_reset();
    n_checks++; if (pad_oeb !== ONES) begin n_fail++; $display("FAIL reset_oeb: got %h want %h", pad_oeb, ONES); end
    n_checks++; if (pad_o !== '0) begin n_fail++; $display("FAIL reset_pad_o: got %h want 00", pad_o); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    for (int a = 0; a < 8; a++) begin
      reg_addr = 3'(a);
      tick();
      exp = (a == 1) ? ONES : '0;
      n_checks++;
      if (reg_rdata !== exp) begin n_fail++; $display("FAIL reset_read[%0d]: got %h want %h", a, reg_rdata, exp); end
    end
  endtask

  task automatic test_set_clr();
    logic [W-1:0] v;
    wr(3'd0, 8'hA5); wr(3'd6, 8'h02); wr(3'd7, 8'h80);
    n_checks++; if (pad_o !== 8'h27) begin n_fail++; $display("FAIL set_clr_pad_o: got %h want 27", pad_o); end
    n_checks++; if (reg_rdata !== 8'h00) begin n_fail++; $display("FAIL read_clr_addr: got %h want 00", reg_rdata); end
    reg_addr = 3'd0;
    tick();
    n_checks++; if (reg_rdata !== 8'h27) begin n_fail++; $display("FAIL read_data_out: got %h want 27", reg_rdata); end
    wr(3'd2, 8'hFF);
    reg_addr = 3'd2;
    tick();
    n_checks++; if (reg_rdata !== 8'h00) begin n_fail++; $display("FAIL data_in_ro: got %h want 00", reg_rdata); end
    n_checks++; if (pad_o !== 8'h27) begin n_fail++; $display("FAIL data_in_write_side: got %h want 27", pad_o); end
    v = W'($urandom);
    wr(3'd1, v);
    reg_addr = 3'd1;
    tick();
    n_checks++; if (reg_rdata !== v) begin n_fail++; $display("FAIL read_oeb: got %h want %h", reg_rdata, v); end
    n_checks++; if (pad_oeb !== v) begin n_fail++; $display("FAIL pad_oeb: got %h want %h", pad_oeb, v); end
  endtask

  task automatic test_edge_irq();
    int n = 0;
    bit seen = 0;
    pad_i = '0;
    repeat (LAT + 2) tick();
    wr(3'd3, 8'h01); wr(3'd4, 8'h01);
    reg_addr = 3'd2;
    pad_i[0] = 1'b1;
    for (int c = 1; c <= LAT + 10 && !seen; c++) begin
      tick();
      if (irq === 1'b1) begin seen = 1; n = c; end
    end
    n_checks++; if (!seen || n != LAT + 1) begin n_fail++; $display("FAIL rise_irq_latency: got %0d want %0d", n, LAT + 1); end
    n_checks++; if (reg_rdata[0] !== 1'b1) begin n_fail++; $display("FAIL rise_data_in: got %b want 1", reg_rdata[0]); end
    wr(3'd5, 8'h01);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_clear: got %b want 0", irq); end
  endtask

  task automatic test_w1c_collision();
    wr(3'd4, 8'h00);
    pad_i[0] = 1'b0;
    repeat (LAT) tick();
    wr(3'd5, 8'h01);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL set_beats_w1c: got %b want 1", irq); end
    wr(3'd3, 8'h00);
    tick();
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL en_clear_keeps_status: got %b want 1", irq); end
    wr(3'd5, 8'h01);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_after_collision: got %b want 0", irq); end
    wr(3'd3, 8'hFF); wr(3'd4, 8'hFF); wr(3'd4, 8'h00); wr(3'd4, 8'hAA);
    repeat (3) tick();
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_cfg_no_event: got %b want 0", irq); end
  endtask

  task automatic test_debounce();
    int n = 0;
    bit seen = 0;
    wr(3'd3, 8'h02); wr(3'd4, 8'h02); wr(3'd5, 8'hFF);
    reg_addr = 3'd2;
`ifdef GPIO_BANK_DEBOUNCE_EN
    pad_i[1] = 1'b1;
    repeat (10) tick();
    pad_i[1] = 1'b0;
    repeat (LAT + 5) tick();
    n_checks++; if (reg_rdata[1] !== 1'b0) begin n_fail++; $display("FAIL short_pulse_data_in: got %b want 0", reg_rdata[1]); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL short_pulse_irq: got %b want 0", irq); end
    pad_i[1] = 1'b1;
    for (int c = 1; c <= LAT + 10 && !seen; c++) begin
      tick();
      if (reg_rdata[1] === 1'b1) begin seen = 1; n = c; end
    end
    n_checks++; if (!seen || n != S + DC + 1) begin n_fail++; $display("FAIL long_pulse_latency: got %0d want %0d", n, S + DC + 1); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL long_pulse_irq: got %b want 1", irq); end
    if (n < 20) repeat (20 - n) tick();
`else
    pad_i[1] = 1'b1;
    tick();
    pad_i[1] = 1'b0;
    repeat (S + 2) tick();
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL unfiltered_pulse_irq: got %b want 1", irq); end
`endif
    pad_i[1] = 1'b0;
    repeat (LAT + 3) tick();
    wr(3'd5, 8'hFF);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL debounce_cleanup: got %b want 0", irq); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, TOGGLE_ODDS - 1) == 0) pad_i = W'($urandom);
      reg_addr  = 3'($urandom_range(0, 7));
      reg_we    = ($urandom_range(0, 3) == 0);
      reg_wdata = W'($urandom);
      tick();
      n_checks++; if (reg_rdata !== m_rdata) begin n_fail++; $display("FAIL rand_rdata@%0d: got %h want %h", c, reg_rdata, m_rdata); end
      n_checks++; if (pad_o !== m_out) begin n_fail++; $display("FAIL rand_pad_o@%0d: got %h want %h", c, pad_o, m_out); end
      n_checks++; if (pad_oeb !== m_oeb) begin n_fail++; $display("FAIL rand_pad_oeb@%0d: got %h want %h", c, pad_oeb, m_oeb); end
      n_checks++; if (irq !== (|m_stat)) begin n_fail++; $display("FAIL rand_irq@%0d: got %b want %b", c, irq, |m_stat); end
    end
    reg_we = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] exp;
    reg_we = 1'b0;
    pad_i  = '0;
    repeat (LAT + 3) tick();
    wr(3'd5, 8'hFF); wr(3'd3, 8'hFF); wr(3'd4, 8'hFF); wr(3'd0, 8'h5A);
    pad_i = 8'hFF;
    repeat (LAT + 1) tick();
    reg_addr = 3'd5;
    tick();
    n_checks++; if (reg_rdata !== 8'hFF) begin n_fail++; $display("FAIL pre_reset_status: got %h want ff", reg_rdata); end
    #2;
    core_rstn = 1'b0;
    model_reset();
    #1;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL async_irq_drop: got %b want 0", irq); end
    n_checks++; if (pad_o !== '0) begin n_fail++; $display("FAIL async_pad_o: got %h want 00", pad_o); end
    n_checks++; if (pad_oeb !== ONES) begin n_fail++; $display("FAIL async_pad_oeb: got %h want %h", pad_oeb, ONES); end
    n_checks++; if (reg_rdata !== '0) begin n_fail++; $display("FAIL async_rdata: got %h want 00", reg_rdata); end
    repeat (2) @(posedge core_clk);
    #1;
    core_rstn = 1'b1;
    for (int a = 0; a < 8; a++) begin
      reg_addr = 3'(a);
      tick();
      n_checks++;
      if (reg_rdata !== m_rdata) begin n_fail++; $display("FAIL post_reset_read[%0d]: got %h want %h", a, reg_rdata, m_rdata); end
      if (a != 2) begin
        exp = (a == 1) ? ONES : '0;
        n_checks++;
        if (reg_rdata !== exp) begin n_fail++; $display("FAIL post_reset_value[%0d]: got %h want %h", a, reg_rdata, exp); end
      end
    end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL post_reset_irq: got %b want 0", irq); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_set_clr();
    test_edge_irq();
    test_w1c_collision();
    test_debounce();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
